// File: rtl/gbhr_spec_ckpt_if.sv
// rtl/gbhr_spec_ckpt_if.sv - branch-history request/status bundle between front end and GBHR
interface gbhr_spec_ckpt_if #(
    parameter int W_HIST = 4,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              predict;
    logic              pred_taken;
    logic              resolve;
    logic              act_taken;
    logic [W_HIST-1:0] gbhr;
    logic [W_HIST-1:0] gbhr_commit;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              mispredict;

    modport master (
        output predict, pred_taken, resolve, act_taken,
        input  gbhr, gbhr_commit, count, full, empty, mispredict
    );

    modport slave (
        input  predict, pred_taken, resolve, act_taken,
        output gbhr, gbhr_commit, count, full, empty, mispredict
    );
endinterface

// File: rtl/gbhr_spec_ckpt.sv
// rtl/gbhr_spec_ckpt.sv - speculative global branch history with in-order checkpoint queue
module gbhr_spec_ckpt #(
    parameter int W_HIST = 4,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    gbhr_spec_ckpt_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    // One checkpoint: the history before the branch was shifted in, plus its prediction.
    typedef struct packed {
        logic [W_HIST-1:0] hist;
        logic              pred;
    } ckpt_t;

    ckpt_t             mem_q [DEPTH];
    ckpt_t             mem_d [DEPTH];
    logic [W_HIST-1:0] gbhr_q, gbhr_d;
    logic [W_HIST-1:0] commit_q, commit_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              mispredict_q, mispredict_d;

    logic              full_w;
    logic              empty_w;
    logic              res_valid;
    logic              mis;
    logic              res_ok;
    logic              push;
    ckpt_t             oldest;

    function automatic logic [W_HIST-1:0] shift_in(input logic [W_HIST-1:0] h, input logic b);
        return {h[W_HIST-2:0], b};
    endfunction

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Request decode and next-state: a misprediction flushes the queue and wins over any same-cycle predict.
    always_comb begin
        oldest       = mem_q[rd_ptr_q];
        res_valid    = EN && bus.resolve && !empty_w;
        mis          = res_valid && (bus.act_taken != oldest.pred);
        res_ok       = res_valid && !mis;
        push         = EN && bus.predict && (!full_w || res_ok) && !mis;

        mem_d        = mem_q;
        gbhr_d       = gbhr_q;
        commit_d     = commit_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        mispredict_d = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = '{hist: gbhr_q, pred: bus.pred_taken};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            gbhr_d          = shift_in(gbhr_q, bus.pred_taken);
        end

        if (res_valid) begin
            commit_d = shift_in(oldest.hist, bus.act_taken);
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (mis) begin
            gbhr_d       = shift_in(oldest.hist, bus.act_taken);
            count_d      = '0;
            wr_ptr_d     = rd_ptr_q + PW'(1);
            mispredict_d = 1'b1;
        end else begin
            count_d = count_q + CW'(push) - CW'(res_ok);
        end
    end

    // State registers; reset drops all checkpoints at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            gbhr_q       <= '0;
            commit_q     <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            mispredict_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            gbhr_q       <= gbhr_d;
            commit_q     <= commit_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign bus.gbhr        = gbhr_q;
    assign bus.gbhr_commit = commit_q;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.mispredict  = mispredict_q;
endmodule

// File: tb/tb_gbhr_spec_ckpt.sv
// tb/tb_gbhr_spec_ckpt.sv - scoreboard testbench for gbhr_spec_ckpt
module tb_gbhr_spec_ckpt;
    logic clk;
    logic rst;
    logic en;

    gbhr_spec_ckpt_if #(.W_HIST(4), .DEPTH(4)) bus ();

    gbhr_spec_ckpt #(.W_HIST(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .EN  (en),
        .bus (bus.slave)
    );

    typedef struct {
        string      name;
        logic [3:0] g;
        logic [3:0] c;
        logic [2:0] n;
        logic       m;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, want);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.name, ".gbhr"},        32'(bus.gbhr),        32'(e.g));
        chk({e.name, ".gbhr_commit"}, 32'(bus.gbhr_commit), 32'(e.c));
        chk({e.name, ".count"},       32'(bus.count),       32'(e.n));
        chk({e.name, ".full"},        32'(bus.full),        32'(e.n == 3'd4));
        chk({e.name, ".empty"},       32'(bus.empty),       32'(e.n == 3'd0));
        chk({e.name, ".mispredict"},  32'(bus.mispredict),  32'(e.m));
    endtask

    // Monitor: every negedge, compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk_all(exp_q.pop_front());
        end
    end

    // Drive one cycle of stimulus; the expectation is queued once the sampling edge has occurred.
    task automatic step(input string nm, input logic e, input logic pr, input logic pt,
                        input logic rs, input logic at,
                        input logic [3:0] g, input logic [3:0] c, input logic [2:0] n, input logic m);
        exp_t x;
        @(negedge clk);
        en             = e;
        bus.predict    = pr;
        bus.pred_taken = pt;
        bus.resolve    = rs;
        bus.act_taken  = at;
        @(posedge clk);
        x.name = nm; x.g = g; x.c = c; x.n = n; x.m = m;
        exp_q.push_back(x);
    endtask

    task automatic drain;
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        exp_t r;
        en = 1'b1;
        bus.predict = 1'b0; bus.pred_taken = 1'b0;
        bus.resolve = 1'b0; bus.act_taken  = 1'b0;
        rst = 1'b0;
        #3;
        r.name = "reset"; r.g = 4'h0; r.c = 4'h0; r.n = 3'd0; r.m = 1'b0;
        chk_all(r);
        @(negedge clk);
        rst = 1'b1;

        //   name         en pr pt rs at  gbhr     commit   cnt  mis
        step("pred1",     1, 1, 1, 0, 0, 4'b0001, 4'b0000, 3'd1, 0);
        step("pred2",     1, 1, 0, 0, 0, 4'b0010, 4'b0000, 3'd2, 0);
        step("pred3",     1, 1, 1, 0, 0, 4'b0101, 4'b0000, 3'd3, 0);
        step("res_ok",    1, 0, 0, 1, 1, 4'b0101, 4'b0001, 3'd2, 0);
        step("res_mis",   1, 0, 0, 1, 1, 4'b0011, 4'b0011, 3'd0, 1);
        step("mis_pulse", 1, 0, 0, 0, 0, 4'b0011, 4'b0011, 3'd0, 0);
        step("fill1",     1, 1, 1, 0, 0, 4'b0111, 4'b0011, 3'd1, 0);
        step("fill2",     1, 1, 1, 0, 0, 4'b1111, 4'b0011, 3'd2, 0);
        step("fill3",     1, 1, 1, 0, 0, 4'b1111, 4'b0011, 3'd3, 0);
        step("fill4",     1, 1, 1, 0, 0, 4'b1111, 4'b0011, 3'd4, 0);
        step("full_drop", 1, 1, 0, 0, 0, 4'b1111, 4'b0011, 3'd4, 0);
        step("wrap1",     1, 1, 0, 1, 1, 4'b1110, 4'b0111, 3'd4, 0);
        step("wrap2",     1, 1, 0, 1, 1, 4'b1100, 4'b1111, 3'd4, 0);
        step("wrap3",     1, 1, 0, 1, 1, 4'b1000, 4'b1111, 3'd4, 0);
        step("wrap4",     1, 1, 0, 1, 1, 4'b0000, 4'b1111, 3'd4, 0);
        step("wrap5",     1, 1, 1, 1, 0, 4'b0001, 4'b1110, 3'd4, 0);
        step("wrap6",     1, 1, 1, 1, 0, 4'b0011, 4'b1100, 3'd4, 0);
        step("wrap7",     1, 1, 1, 1, 0, 4'b0111, 4'b1000, 3'd4, 0);
        step("wrap8",     1, 1, 1, 1, 0, 4'b1111, 4'b0000, 3'd4, 0);
        step("res_ok2",   1, 0, 0, 1, 1, 4'b1111, 4'b0001, 3'd3, 0);
        step("mis_pred",  1, 1, 1, 1, 0, 4'b0010, 4'b0010, 3'd0, 1);
        step("res_empty", 1, 0, 0, 1, 1, 4'b0010, 4'b0010, 3'd0, 0);
        step("p_a",       1, 1, 1, 0, 0, 4'b0101, 4'b0010, 3'd1, 0);
        step("p_b",       1, 1, 1, 0, 0, 4'b1011, 4'b0010, 3'd2, 0);
        step("p_c",       1, 1, 0, 0, 0, 4'b0110, 4'b0010, 3'd3, 0);
        step("en0_a",     0, 1, 1, 1, 0, 4'b0110, 4'b0010, 3'd3, 0);
        step("en0_b",     0, 1, 0, 1, 1, 4'b0110, 4'b0010, 3'd3, 0);
        step("en0_c",     0, 0, 1, 1, 0, 4'b0110, 4'b0010, 3'd3, 0);
        drain();

        // Asynchronous reset between clock edges with three branches in flight.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        r.name = "async_rst"; r.g = 4'h0; r.c = 4'h0; r.n = 3'd0; r.m = 1'b0;
        chk_all(r);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst",  1, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'd0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
